// File: rtl/vpe_feed_pkg.sv
// rtl/vpe_feed_pkg.sv - shared constants, types and helpers for the VPE feature feeder
//   WORD_W/FEAT_W/NWORDS/DEPTH : datapath geometry
//   feat_vec_t                 : one packed feature vector
//   req_state_t                : fetch request FSM states
//   pack_mode_t                : packer mode (filling a vector or discarding packet overflow)
//   sat_inc                    : 16-bit saturating increment
package vpe_feed_pkg;

  localparam int WORD_W = 32;
  localparam int FEAT_W = 256;
  localparam int NWORDS = FEAT_W / WORD_W;
  localparam int DEPTH  = 4;
  localparam int WIDX_W = $clog2(NWORDS);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [FEAT_W-1:0] feat_vec_t;

  typedef enum logic {REQ_IDLE, REQ_PEND} req_state_t;

  typedef enum logic {PACK_FILL, DISCARD} pack_mode_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vpe_feat_fifo.sv
// rtl/vpe_feat_fifo.sv - synchronous DEPTH x FEAT_W vector FIFO with registered storage
//   clk, rst (sync, active-low)
//   push, push_data : write one vector (caller guarantees not full)
//   pop             : retire the head (caller guarantees not empty)
//   head            : current head vector, read from registered storage
//   count/full/empty: occupancy, updated the edge after push/pop
module vpe_feat_fifo
  import vpe_feed_pkg::*;
#(
  parameter int N = DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  feat_vec_t              push_data,
  input  logic                   pop,
  output feat_vec_t              head,
  output logic [$clog2(N):0]     count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;

  feat_vec_t        mem [N];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == (PTR_W+1)'(N));
  assign empty = (count == '0);

endmodule

// File: rtl/vpe_feature_feeder.sv
// rtl/vpe_feature_feeder.sv - packs 32-bit feature words into 256-bit vectors and serves kernel fetches
//   clk, rst (sync, active-low)
//   s_word/s_valid/s_last/s_ready : upstream word stream
//   fetch_pkt_feature             : one-cycle request from the kernel
//   pkt_feature_valid/pkt_feature : one-cycle response, vector zero when not valid
//   fifo_count                    : vectors buffered
//   short_pkts/long_pkts/dup_fetch: saturating event counters
module vpe_feature_feeder
  import vpe_feed_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_word,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fetch_pkt_feature,
  output logic              pkt_feature_valid,
  output logic [FEAT_W-1:0] pkt_feature,
  output logic [2:0]        fifo_count,
  output logic [15:0]       short_pkts,
  output logic [15:0]       long_pkts,
  output logic [15:0]       dup_fetch
);

  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NWORDS - 1);
  localparam logic [WIDX_W-1:0] WIDX_ONE  = 1;

  feat_vec_t         acc_vec;
  feat_vec_t         commit_vec;
  feat_vec_t         head;
  logic [WIDX_W-1:0] widx;
  pack_mode_t        mode;
  req_state_t        state, state_nxt;
  logic              accept, commit, short_hit, long_hit;
  logic              pop, dup_hit;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  count;

  // Readiness depends only on registered occupancy, so a pop in the same
  // cycle never opens room for a word.
  assign s_ready    = rst & ~fifo_full;
  assign accept     = s_valid & s_ready;
  assign fifo_count = count;

  always_comb begin
    commit_vec = acc_vec;
    commit_vec[widx*WORD_W +: WORD_W] = s_word;
    commit    = 1'b0;
    short_hit = 1'b0;
    long_hit  = 1'b0;
    if (accept && mode == PACK_FILL) begin
      if (widx == WIDX_LAST) begin
        commit   = 1'b1;
        long_hit = ~s_last;
      end else if (s_last) begin
        commit    = 1'b1;
        short_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_vec <= '0;
      widx    <= '0;
      mode    <= PACK_FILL;
    end else if (accept) begin
      if (mode == DISCARD) begin
        if (s_last) mode <= PACK_FILL;
      end else if (commit) begin
        acc_vec <= '0;
        widx    <= '0;
        if (long_hit) mode <= DISCARD;
      end else begin
        acc_vec <= commit_vec;
        widx    <= widx + WIDX_ONE;
      end
    end
  end

  vpe_feat_fifo #(.N(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (commit),
    .push_data (commit_vec),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= REQ_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    dup_hit   = 1'b0;
    case (state)
      REQ_IDLE: begin
        if (fetch_pkt_feature) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = REQ_PEND;
        end
      end
      REQ_PEND: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // A fetch landing on the servicing cycle is a fresh request; keeping
          // PEND is the same as evaluating it from IDLE one cycle later.
          state_nxt = fetch_pkt_feature ? REQ_PEND : REQ_IDLE;
        end else if (fetch_pkt_feature) begin
          dup_hit = 1'b1;
        end
      end
      default: state_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_feature_valid <= 1'b0;
      pkt_feature       <= '0;
      short_pkts        <= '0;
      long_pkts         <= '0;
      dup_fetch         <= '0;
    end else begin
      pkt_feature_valid <= pop;
      pkt_feature       <= pop ? head : '0;
      if (short_hit) short_pkts <= sat_inc(short_pkts);
      if (long_hit)  long_pkts  <= sat_inc(long_pkts);
      if (dup_hit)   dup_fetch  <= sat_inc(dup_fetch);
    end
  end

endmodule

// File: tb/tb_vpe_feature_feeder.sv
// tb/tb_vpe_feature_feeder.sv - directed and randomized bench with a queue-based reference model
module tb_vpe_feature_feeder;

  logic         clk;
  logic         rst;
  logic [31:0]  s_word;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         fetch_pkt_feature;
  logic         pkt_feature_valid;
  logic [255:0] pkt_feature;
  logic [2:0]   fifo_count;
  logic [15:0]  short_pkts;
  logic [15:0]  long_pkts;
  logic [15:0]  dup_fetch;

  vpe_feature_feeder dut (
    .clk               (clk),
    .rst               (rst),
    .s_word            (s_word),
    .s_valid           (s_valid),
    .s_last            (s_last),
    .s_ready           (s_ready),
    .fetch_pkt_feature (fetch_pkt_feature),
    .pkt_feature_valid (pkt_feature_valid),
    .pkt_feature       (pkt_feature),
    .fifo_count        (fifo_count),
    .short_pkts        (short_pkts),
    .long_pkts         (long_pkts),
    .dup_fetch         (dup_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: words of the packet in progress, visible vector queue,
  // one outstanding-request flag, and counters.
  logic [31:0]  cur_q[$];
  logic [255:0] fq[$];
  bit           disc;
  bit           pend;
  int           m_short, m_long, m_dup;
  bit           m_valid;
  logic [255:0] m_feat;
  bit           last_acc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int x);
    return (x < 65535) ? x + 1 : x;
  endfunction

  task automatic commit_vec();
    logic [255:0] v = '0;
    foreach (cur_q[i]) v[i*32 +: 32] = cur_q[i];
    fq.push_back(v);
    cur_q.delete();
  endtask

  task automatic model_step(input bit r, input bit acc, input bit l, input bit f, input logic [31:0] w);
    bit served = 0;
    logic [255:0] sv = '0;
    if (!r) begin
      cur_q.delete(); fq.delete();
      disc = 0; pend = 0; m_short = 0; m_long = 0; m_dup = 0;
      m_valid = 0; m_feat = '0;
      return;
    end
    if (!pend) begin
      if (f) begin
        if (fq.size() > 0) begin sv = fq.pop_front(); served = 1; end
        else pend = 1;
      end
    end else begin
      if (fq.size() > 0) begin sv = fq.pop_front(); served = 1; pend = f; end
      else if (f) m_dup = sat16(m_dup);
    end
    if (acc) begin
      if (disc) begin
        if (l) disc = 0;
      end else begin
        cur_q.push_back(w);
        if (cur_q.size() == 8) begin
          commit_vec();
          if (!l) begin disc = 1; m_long = sat16(m_long); end
        end else if (l) begin
          commit_vec();
          m_short = sat16(m_short);
        end
      end
    end
    m_valid = served;
    m_feat  = served ? sv : '0;
  endtask

  task automatic cyc(input bit r, input bit v, input bit l, input bit f, input logic [31:0] w);
    bit exp_ready;
    rst = r; s_valid = v; s_last = l; fetch_pkt_feature = f; s_word = w;
    #1;
    exp_ready = r && (fq.size() < 4);
    check("s_ready_pre", {255'd0, s_ready}, {255'd0, exp_ready});
    last_acc = v && exp_ready;
    model_step(r, last_acc, l, f, w);
    @(posedge clk);
    #1;
    check("valid", {255'd0, pkt_feature_valid}, {255'd0, m_valid});
    check("feature", pkt_feature, m_feat);
    check("fifo_count", {253'd0, fifo_count}, 256'(fq.size()));
    check("short_pkts", {240'd0, short_pkts}, 256'(m_short));
    check("long_pkts", {240'd0, long_pkts}, 256'(m_long));
    check("dup_fetch", {240'd0, dup_fetch}, 256'(m_dup));
  endtask

  task automatic send_word(input logic [31:0] w, input bit l);
    int tries = 0;
    do begin
      cyc(1, 1, l, 0, w);
      tries++;
    end while (!last_acc && tries < 20);
    check("send_accept", {255'd0, last_acc}, 256'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (fq.size() == 0 && !pend) break;
      cyc(1, 0, 0, !pend, 32'd0);
    end
    check("drain_empty", {253'd0, fifo_count}, 256'd0);
  endtask

  initial begin
    rst = 0; s_valid = 0; s_last = 0; fetch_pkt_feature = 0; s_word = '0;
    disc = 0; pend = 0; m_short = 0; m_long = 0; m_dup = 0; m_valid = 0; m_feat = '0;

    // reset
    cyc(0, 0, 0, 0, 32'd0);
    cyc(0, 0, 0, 0, 32'd0);
    check("reset_ready", {255'd0, s_ready}, 256'd0);

    // 1: full 8-word packet then one fetch
    for (int k = 1; k <= 8; k++) send_word(32'h11111111 * k, k == 8);
    check("t1_count1", {253'd0, fifo_count}, 256'd1);
    cyc(1, 0, 0, 1, 32'd0);
    check("t1_valid", {255'd0, pkt_feature_valid}, 256'd1);
    check("t1_lsw", {224'd0, pkt_feature[31:0]}, 256'h11111111);
    check("t1_msw", {224'd0, pkt_feature[255:224]}, 256'h88888888);
    check("t1_count0", {253'd0, fifo_count}, 256'd0);
    cyc(1, 0, 0, 0, 32'd0);
    check("t1_single_strobe", {255'd0, pkt_feature_valid}, 256'd0);

    // 2: fetch on empty FIFO, words arrive 3 cycles later
    cyc(1, 0, 0, 1, 32'd0);
    repeat (3) cyc(1, 0, 0, 0, 32'd0);
    for (int k = 0; k < 8; k++) send_word(32'hA0000000 + k, k == 7);
    check("t2_no_early", {255'd0, pkt_feature_valid}, 256'd0);
    cyc(1, 0, 0, 0, 32'd0);
    check("t2_valid", {255'd0, pkt_feature_valid}, 256'd1);
    cyc(1, 0, 0, 0, 32'd0);

    // 3: short packet A,B,C
    send_word(32'hAAAA0001, 0);
    send_word(32'hBBBB0002, 0);
    send_word(32'hCCCC0003, 1);
    cyc(1, 0, 0, 1, 32'd0);
    check("t3_vec", pkt_feature, {160'd0, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
    check("t3_short", {240'd0, short_pkts}, 256'd1);

    // 4: 11-word packet truncated to 8
    for (int k = 1; k <= 11; k++) send_word(32'h40000000 + k, k == 11);
    check("t4_long", {240'd0, long_pkts}, 256'd1);
    check("t4_count", {253'd0, fifo_count}, 256'd1);
    drain();

    // 5: fill four vectors, back-pressure, pop, fifth vector
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) send_word({16'h5000 + 16'(p), 16'(k)}, k == 7);
    cyc(1, 1, 0, 0, 32'h50040000);
    check("t5_full_ready", {255'd0, s_ready}, 256'd0);
    cyc(1, 1, 0, 1, 32'h50040000);
    check("t5_ready_after_pop", {255'd0, s_ready}, 256'd1);
    for (int k = 0; k < 8; k++) send_word({16'h5004, 16'(k)}, k == 7);
    check("t5_count", {253'd0, fifo_count}, 256'd4);
    drain();

    // 6: duplicate fetch, then reset mid-packet
    cyc(1, 0, 0, 1, 32'd0);
    cyc(1, 0, 0, 1, 32'd0);
    check("t6_dup", {240'd0, dup_fetch}, 256'd1);
    send_word(32'h60000001, 0);
    send_word(32'h60000002, 0);
    cyc(0, 0, 0, 0, 32'd0);
    check("t6_rst_dup", {240'd0, dup_fetch}, 256'd0);
    check("t6_rst_ready", {255'd0, s_ready}, 256'd0);
    check("t6_rst_valid", {255'd0, pkt_feature_valid}, 256'd0);
    for (int k = 0; k < 8; k++) send_word(32'h61000000 + k, k == 7);
    cyc(1, 0, 0, 1, 32'd0);
    check("t6_word0", {224'd0, pkt_feature[31:0]}, 256'h61000000);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
